// File: rtl/eth_frame_loop_pkg.sv
// Shared definitions for the frame loopback buffer: write-FSM state codes,
// tuser field positions and the pointer sizing helper.
package eth_frame_loop_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SYNC    = 2'd0;
  localparam state_t ST_IDLE    = 2'd1;
  localparam state_t ST_WRITE   = 2'd2;
  localparam state_t ST_DISCARD = 2'd3;

  typedef enum int {
    FCS_INVALID = 0,
    DROP_FRAME  = 1
  } tuser_field_e;

  // Address bits for a power-of-two depth plus one wrap bit.
  function automatic int clog2_ptr(input int depth);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < depth) begin
        bits = i + 1;
      end else begin
        bits = bits;
      end
    end
    return bits + 1;
  endfunction

endpackage

// File: rtl/eth_frame_loop_ctl_fifo.sv
// Single-clock first-word-fall-through FIFO holding one control word per
// committed frame; pushes while full and pops while empty are ignored.
module eth_frame_loop_ctl_fifo
  import eth_frame_loop_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2_ptr(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (wr_ptr_r - rd_ptr_r) == PW'(DEPTH);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

endmodule

// File: rtl/eth_frame_loop_buffer.sv
// Store-and-forward frame buffer for the frame detector loopback path.
// Optional frame statistics outputs are enabled by ETH_FRAME_LOOP_STATS_EN.
module eth_frame_loop_buffer
  import eth_frame_loop_pkg::*;
#(
  parameter int C_BYTES       = 1,
  parameter int C_FRAME_DEPTH = 2048,
  parameter int C_CTL_DEPTH   = 64,
  parameter int C_CTL_WIDTH   = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*C_BYTES-1:0]   s_axis_tdata,
  input  logic [C_BYTES-1:0]     s_axis_tkeep,
  input  logic [C_CTL_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic [8*C_BYTES-1:0]   m_axis_frame_tdata,
  output logic [C_BYTES-1:0]     m_axis_frame_tkeep,
  output logic                   m_axis_frame_tlast,
  output logic                   m_axis_frame_tvalid,
  input  logic                   m_axis_frame_tready,
  output logic [C_CTL_WIDTH-1:0] m_axis_ctl_tdata,
  output logic                   m_axis_ctl_tvalid,
  input  logic                   m_axis_ctl_tready,
  output logic                   drop_pulse
`ifdef ETH_FRAME_LOOP_STATS_EN
  ,
  output logic [31:0]            frames_ok_count,
  output logic [31:0]            frames_drop_count
`endif
);

  localparam int DW = 8 * C_BYTES;
  localparam int MW = 1 + C_BYTES + DW;
  localparam int PW = clog2_ptr(C_FRAME_DEPTH);
  localparam int AW = PW - 1;

  logic [MW-1:0] mem_r [C_FRAME_DEPTH];
  logic [PW-1:0] wr_ptr_r, cm_ptr_r, rd_ptr_r;
  logic [PW-1:0] wr_ptr_s, cm_ptr_s;
  state_t        state_r, state_s;
  logic          store_s, commit_s, drop_s;
  logic          mem_full_s, ctl_full_s, ctl_empty_s;
  logic          drop_pulse_r;
  logic [MW-1:0] out_r;
  logic          out_valid_r;
  logic          load_s;

  // Conservative: rd_ptr is the value before any same-cycle read.
  assign mem_full_s = (wr_ptr_r - rd_ptr_r) == PW'(C_FRAME_DEPTH);
  assign load_s     = (rd_ptr_r != cm_ptr_r) && (!out_valid_r || m_axis_frame_tready);

  // Write FSM: one decision per valid input beat.
  always_comb begin
    state_s  = state_r;
    wr_ptr_s = wr_ptr_r;
    cm_ptr_s = cm_ptr_r;
    store_s  = 1'b0;
    commit_s = 1'b0;
    drop_s   = 1'b0;
    if (s_axis_tvalid) begin
      case (state_r)
        ST_SYNC: begin
          state_s = s_axis_tlast ? ST_IDLE : ST_SYNC;
        end
        ST_IDLE, ST_WRITE: begin
          if ((state_r == ST_IDLE) && ctl_full_s) begin
            drop_s  = 1'b1;
            state_s = s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else if (mem_full_s) begin
            wr_ptr_s = cm_ptr_r;
            drop_s   = 1'b1;
            state_s  = s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else begin
            store_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PW'(1);
            if (s_axis_tlast) begin
              commit_s = 1'b1;
              cm_ptr_s = wr_ptr_r + PW'(1);
              state_s  = ST_IDLE;
            end else begin
              state_s  = ST_WRITE;
            end
          end
        end
        ST_DISCARD: begin
          state_s = s_axis_tlast ? ST_IDLE : ST_DISCARD;
        end
        default: begin
          state_s = ST_SYNC;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Write-side state and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_SYNC;
      wr_ptr_r     <= '0;
      cm_ptr_r     <= '0;
      drop_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= wr_ptr_s;
      cm_ptr_r     <= cm_ptr_s;
      drop_pulse_r <= drop_s;
    end
  end

  // Frame memory with a registered read port that doubles as the output stage.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
    if (load_s) begin
      out_r <= mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Output valid and read pointer: refill whenever the output slot frees up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      rd_ptr_r    <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      rd_ptr_r    <= rd_ptr_r + PW'(1);
    end else if (m_axis_frame_tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign m_axis_frame_tdata  = out_r[DW-1:0];
  assign m_axis_frame_tkeep  = out_r[DW +: C_BYTES];
  assign m_axis_frame_tlast  = out_r[MW-1];
  assign m_axis_frame_tvalid = out_valid_r;
  assign m_axis_ctl_tvalid   = !ctl_empty_s;
  assign drop_pulse          = drop_pulse_r;

  eth_frame_loop_ctl_fifo #(
    .DEPTH (C_CTL_DEPTH),
    .WIDTH (C_CTL_WIDTH)
  ) u_ctl_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (commit_s),
    .push_data (s_axis_tuser),
    .pop       (m_axis_ctl_tready),
    .pop_data  (m_axis_ctl_tdata),
    .full      (ctl_full_s),
    .empty     (ctl_empty_s)
  );

`ifdef ETH_FRAME_LOOP_STATS_EN
  logic [31:0] ok_cnt_r;
  logic [31:0] drop_cnt_r;

  // Saturating commit and drop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_cnt_r   <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (commit_s && (ok_cnt_r != 32'hFFFF_FFFF))   ok_cnt_r   <= ok_cnt_r + 32'd1;
      if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF))   drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

  assign frames_ok_count   = ok_cnt_r;
  assign frames_drop_count = drop_cnt_r;
`endif

endmodule

// File: tb/tb_eth_frame_loop_buffer.sv
// Directed bench for eth_frame_loop_buffer (4-byte beats, 16-beat memory,
// 2-entry control FIFO) with a scoreboard of hand-built expected beats.
module tb_eth_frame_loop_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [47:0] s_user;
  logic        s_last;
  logic        s_valid;
  logic [31:0] f_data;
  logic [3:0]  f_keep;
  logic        f_last;
  logic        f_valid;
  logic        f_ready;
  logic [47:0] c_data;
  logic        c_valid;
  logic        c_ready;
  logic        drop_pulse;

  int          n_vec = 0;
  int          n_bad = 0;
  int          drop_seen = 0;
  int          recv_beats = 0;
  int          unexp = 0;
  logic        rand_ready = 1'b0;
  logic [36:0] exp_frame [$];
  logic [47:0] exp_ctl [$];
  logic        hold_pend = 1'b0;
  logic [36:0] held;
  logic [36:0] fword;
  int          r0;

  always #5 clk = ~clk;

  assign fword = {f_last, f_keep, f_data};

  eth_frame_loop_buffer #(
    .C_BYTES       (4),
    .C_FRAME_DEPTH (16),
    .C_CTL_DEPTH   (2),
    .C_CTL_WIDTH   (48)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_tdata        (s_data),
    .s_axis_tkeep        (s_keep),
    .s_axis_tuser        (s_user),
    .s_axis_tlast        (s_last),
    .s_axis_tvalid       (s_valid),
    .m_axis_frame_tdata  (f_data),
    .m_axis_frame_tkeep  (f_keep),
    .m_axis_frame_tlast  (f_last),
    .m_axis_frame_tvalid (f_valid),
    .m_axis_frame_tready (f_ready),
    .m_axis_ctl_tdata    (c_data),
    .m_axis_ctl_tvalid   (c_valid),
    .m_axis_ctl_tready   (c_ready),
    .drop_pulse          (drop_pulse)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer-side monitor: scoreboard, hold-stability and drop counting.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check_val("hold_valid", 64'(f_valid), 64'd1);
        check_val("hold_data", 64'(fword), 64'(held));
      end
      hold_pend <= f_valid && !f_ready;
      held      <= fword;
      if (f_valid && f_ready) begin
        recv_beats <= recv_beats + 1;
        if (exp_frame.size() == 0) unexp <= unexp + 1;
        else check_val("frame_beat", 64'(fword), 64'(exp_frame.pop_front()));
      end
      if (c_valid && c_ready) begin
        if (exp_ctl.size() == 0) unexp <= unexp + 1;
        else check_val("ctl_word", 64'(c_data), 64'(exp_ctl.pop_front()));
      end
      if (drop_pulse) drop_seen <= drop_seen + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) f_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [47:0] u);
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_user  = u;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] lk,
                            input logic [47:0] u, input bit keep_it);
    logic       l;
    logic [3:0] k;
    if (keep_it) exp_ctl.push_back(u);
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      k = l ? lk : 4'hF;
      if (keep_it) exp_frame.push_back({l, k, base + 32'(i)});
      send_beat(base + 32'(i), k, l, u);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_frame.size() != 0 || exp_ctl.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    check_val({tag, "_left"}, 64'(exp_frame.size() + exp_ctl.size()), 64'd0);
    repeat (4) tick();
    check_val({tag, "_fvalid_idle"}, 64'(f_valid), 64'd0);
    check_val({tag, "_cvalid_idle"}, 64'(c_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_keep = 4'd0; s_last = 1'b0;
    s_user = 48'd0; f_ready = 1'b1; c_ready = 1'b1;
    repeat (2) tick();
    // Frame already in progress while reset is held; its tail follows release.
    for (int i = 0; i < 3; i++) send_beat(32'hDEAD_0000 + 32'(i), 4'hF, 1'b0, 48'h0);
    check_val("rst_fvalid", 64'(f_valid), 64'd0);
    check_val("rst_cvalid", 64'(c_valid), 64'd0);
    check_val("rst_drop", 64'(drop_pulse), 64'd0);
    rst_n = 1'b1;
    send_frame(5, 32'hDEAD_0010, 4'hF, 48'hBAD0_0000_0001, 1'b0);
    repeat (4) tick();
    check_val("sync_fvalid", 64'(f_valid), 64'd0);
    check_val("sync_cvalid", 64'(c_valid), 64'd0);

    // Latency from an empty buffer: ctl at N+1, first beat at N+2.
    send_frame(8, 32'hA000_0000, 4'hF, 48'h1234_5678_9ABC, 1'b1);
    check_val("lat_ctl_valid", 64'(c_valid), 64'd1);
    check_val("lat_ctl_data", 64'(c_data), 64'h1234_5678_9ABC);
    check_val("lat_f_early", 64'(f_valid), 64'd0);
    tick();
    check_val("lat_f_valid", 64'(f_valid), 64'd1);
    check_val("lat_f_first", 64'(f_data), 64'hA000_0000);
    drain("t1");
    check_val("t1_drops", 64'(drop_seen), 64'd0);

    // Second frame overflows behind a stalled first one.
    f_ready = 1'b0;
    send_frame(10, 32'hB000_0000, 4'hF, 48'h0000_0000_AAAA, 1'b1);
    send_frame(10, 32'hB100_0000, 4'hF, 48'h0000_0000_BBBB, 1'b0);
    repeat (3) tick();
    check_val("t2_drops", 64'(drop_seen), 64'd1);
    check_val("t2_ctl_pending", 64'(exp_ctl.size()), 64'd0);
    check_val("t2_f_held", 64'(f_valid), 64'd1);
    r0 = recv_beats;
    f_ready = 1'b1;
    drain("t2");
    check_val("t2_beats", 64'(recv_beats - r0), 64'd10);

    // Oversized frame into an empty buffer, then a short frame.
    send_frame(20, 32'hC000_0000, 4'hF, 48'h0000_0000_CCCC, 1'b0);
    tick();
    check_val("t3_drops", 64'(drop_seen), 64'd2);
    send_frame(4, 32'hC100_0000, 4'h7, 48'h0000_0000_C4C4, 1'b1);
    drain("t3");

    // Control FIFO full at the start of the third frame.
    c_ready = 1'b0;
    send_frame(2, 32'hD100_0000, 4'hF, 48'h0000_0000_D001, 1'b1);
    send_frame(2, 32'hD200_0000, 4'hF, 48'h0000_0000_D002, 1'b1);
    check_val("t4_ctl_valid", 64'(c_valid), 64'd1);
    check_val("t4_ctl_head", 64'(c_data), 64'h0000_0000_D001);
    send_beat(32'hD300_0000, 4'hF, 1'b0, 48'h0000_0000_D003);
    check_val("t4_drop_first", 64'(drop_pulse), 64'd1);
    send_beat(32'hD300_0001, 4'hF, 1'b1, 48'h0000_0000_D003);
    tick();
    check_val("t4_drops", 64'(drop_seen), 64'd3);
    c_ready = 1'b1;
    drain("t4");

    // Partial last beat under random backpressure.
    rand_ready = 1'b1;
    send_frame(3, 32'hE000_0000, 4'b0011, 48'h0000_0000_E003, 1'b1);
    drain("t6");
    rand_ready = 1'b0;
    f_ready = 1'b1;

    // Reset with a committed, unread frame and a frame in flight.
    f_ready = 1'b0;
    c_ready = 1'b0;
    send_frame(3, 32'hF000_0000, 4'hF, 48'h0000_0000_F003, 1'b0);
    repeat (2) tick();
    check_val("t7_f_before", 64'(f_valid), 64'd1);
    check_val("t7_c_before", 64'(c_valid), 64'd1);
    send_beat(32'hF100_0000, 4'hF, 1'b0, 48'h0);
    rst_n = 1'b0;
    send_beat(32'hF100_0001, 4'hF, 1'b0, 48'h0);
    send_beat(32'hF100_0002, 4'hF, 1'b0, 48'h0);
    check_val("t7_f_reset", 64'(f_valid), 64'd0);
    check_val("t7_c_reset", 64'(c_valid), 64'd0);
    rst_n = 1'b1;
    f_ready = 1'b1;
    c_ready = 1'b1;
    send_frame(2, 32'hF100_0003, 4'hF, 48'h0000_0000_F1F1, 1'b0);
    send_frame(2, 32'hF200_0000, 4'b0001, 48'h0000_0000_F2F2, 1'b1);
    drain("t7");
    check_val("final_drops", 64'(drop_seen), 64'd3);
    check_val("unexpected_beats", 64'(unexp), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_loop_buffer.md
Name: eth_frame_loop_buffer

Overview:
- Single-clock store-and-forward frame buffer for the frame detector loopback path, with a configurable bus width.
- Frames enter from a source with no backpressure and are held until their last beat is written.
- Frame data appears on M_AXIS_FRAME and one control word per frame appears on M_AXIS_CTL.
- A frame that overflows the buffer is dropped in full by rewinding the write pointer. It is never truncated.

Parameters:
- C_BYTES, 1: bytes per beat. tdata is 8*C_BYTES bits wide.
- C_FRAME_DEPTH, 2048: frame memory depth in beats. Power of two, ≥16.
- C_CTL_DEPTH, 64: control FIFO depth in entries. Power of two, ≥2.
- C_CTL_WIDTH, 48: control word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- s_axis_tdata  in  8*C_BYTES  frame data
- s_axis_tkeep  in  C_BYTES  byte enables, meaningful on the last beat only
- s_axis_tuser  in  C_CTL_WIDTH  control word, sampled on the tlast beat
- s_axis_tlast  in  1  end of frame
- s_axis_tvalid  in  1  beat valid; there is no tready
- m_axis_frame_tdata  out  8*C_BYTES  buffered data
- m_axis_frame_tkeep  out  C_BYTES  buffered byte enables
- m_axis_frame_tlast  out  1  end of frame
- m_axis_frame_tvalid  out  1  valid
- m_axis_frame_tready  in  1  ready
- m_axis_ctl_tdata  out  C_CTL_WIDTH  control word
- m_axis_ctl_tvalid  out  1  valid
- m_axis_ctl_tready  in  1  ready
- drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset: all m_axis_*_tvalid=0, drop_pulse=0, all pointers=0, state=ST_SYNC.
- Write pointers:
  - Speculative wr_ptr and committed cm_ptr, each log2(C_FRAME_DEPTH)+1 bits, wrap-around by natural overflow.
  - Frame memory is full when wr_ptr-rd_ptr==C_FRAME_DEPTH.
  - Each memory word holds {tlast, tkeep, tdata}.
- Write FSM, one decision per valid beat:
  - ST_SYNC: skip beats until a tlast beat, then go to ST_IDLE. This discards any frame already in progress when reset releases.
  - ST_IDLE, first beat, control FIFO full: drop_pulse=1. Go to ST_DISCARD, or stay in ST_IDLE if the beat carries tlast.
  - ST_IDLE, first beat, control FIFO not full: treat as ST_WRITE for this same beat.
  - ST_WRITE, frame memory full: wr_ptr<=cm_ptr, drop_pulse=1, go to ST_DISCARD, or to ST_IDLE if the beat carries tlast.
  - ST_WRITE, not full, no tlast: store the beat, wr_ptr++.
  - ST_WRITE, not full, tlast: store the beat, cm_ptr<=wr_ptr+1, push s_axis_tuser to the control FIFO in the same cycle, go to ST_IDLE.
  - ST_DISCARD: ignore beats until tlast, then go to ST_IDLE.
- Control FIFO space:
  - Space is checked only at frame start.
  - If an entry is popped while that frame is in flight, space can only grow, so a push at commit always succeeds.
- Frames longer than C_FRAME_DEPTH beats are always dropped.
- Read side:
  - Data is readable only while rd_ptr!=cm_ptr.
  - The memory read is registered, with a prefetch output register (FWFT).
  - Latency: tlast written at cycle N gives m_axis_ctl_tvalid at N+1 and first-beat m_axis_frame_tvalid at N+2 when the buffer was empty.
  - Output data holds stable while tvalid=1 and tready=0.
  - Sustained throughput is 1 beat/cycle.
- Read and write in the same cycle both proceed. "Full" uses the rd_ptr value from before the read (conservative).
- Control and frame streams are independent. The consumer must pair the k-th control entry with the k-th frame.
- Reset asserted mid-frame clears all contents; committed but unread frames are lost.

Optional Feature:
- Macro: ETH_FRAME_LOOP_STATS_EN.
- When defined, adds two outputs:
  - frames_ok_count (32 bits): increments on each commit.
  - frames_drop_count (32 bits): increments with each drop_pulse.
- Both counters saturate at 2^32-1 and reset to 0.
- When undefined, neither port nor counter exists.

Decomposition:
- Package eth_frame_loop_pkg holds:
  - the state enum (ST_SYNC, ST_IDLE, ST_WRITE, ST_DISCARD);
  - function clog2_ptr(depth);
  - constant for the tuser field positions (FCS_INVALID=0, DROP_FRAME=1).
- Sub-module eth_frame_loop_ctl_fifo: generic single-clock FWFT FIFO with full/empty, used for control words.
- The frame memory and its pointer logic stay in the top module, because cm_ptr rewind is specific to it.

Test Plan:
- C_BYTES=1, single 64-beat frame, tuser=48'h123456789ABC -> m_axis_ctl_tdata=48'h123456789ABC at N+1, 64 frame beats with tlast on beat 64, drop_pulse never set.
- C_FRAME_DEPTH=16, tready=0, frame A 10 beats then frame B 10 beats -> A retained, B dropped (drop_pulse once), one ctl entry; tready=1 then yields exactly 10 beats.
- 20-beat frame into C_FRAME_DEPTH=16 with an empty buffer -> dropped, wr_ptr returns to 0, the following 4-beat frame passes intact.
- C_CTL_DEPTH=2, ctl tready=0, three 2-beat frames -> frames 1-2 stored, frame 3 dropped at its first beat.
- Reset released mid-frame (5 beats before tlast) -> those beats ignored, the next frame is delivered.
- C_BYTES=4, 3-beat frame with last tkeep=4'b0011, random tready -> data/tkeep/tlast match the input and stay stable under backpressure.
